// File: rtl/video_mode_detector.sv
// video_mode_detector: classifies Dreamcast sync timing as 480p/480i with frame-count hysteresis.
// Define FIELD_DETECT_EN to add the interlaced field-parity output.
module video_mode_detector #(
  parameter int LINE_CNT_W    = 11,
  parameter int THRESH_480P   = 400,
  parameter int STABLE_FRAMES = 4,
  parameter int TIMEOUT_W     = 22
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  hsync_n,
  input  logic                  vsync_n,
  output logic                  _480p_active_n,
  output logic                  mode_changed,
  output logic                  locked,
`ifdef FIELD_DETECT_EN
  output logic                  field,
`endif
  output logic [LINE_CNT_W-1:0] line_count
);
  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;
  localparam logic [LINE_CNT_W-1:0] THRESH = LINE_CNT_W'(THRESH_480P);
  localparam logic [3:0] SF = 4'(STABLE_FRAMES);
  state_t state;
  logic hs_r, hs_p, vs_r, vs_p, hs_fall, vs_fall, cand, cls, qualified;
  logic [LINE_CNT_W-1:0] cnt, cnt_next;
  logic [TIMEOUT_W-1:0] wd;
  logic [3:0] stable, stable_next;
  assign hs_fall = hs_p & ~hs_r;
  assign vs_fall = vs_p & ~vs_r;
  // A coincident hsync edge belongs to the frame that is closing.
  assign cnt_next = (hs_fall && cnt != '1) ? cnt + 1'b1 : cnt;
  assign cls = cnt_next >= THRESH;
  assign stable_next = (cls == cand) ? ((stable >= SF) ? SF : stable + 4'd1) : 4'd1;
  assign qualified = stable_next == SF;
`ifdef FIELD_DETECT_EN
  logic field_r;
  assign field = field_r & _480p_active_n;
`endif
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      hs_r <= 1'b1;
      hs_p <= 1'b1;
      vs_r <= 1'b1;
      vs_p <= 1'b1;
      state <= SEARCH;
      cnt <= '0;
      wd <= '0;
      stable <= '0;
      cand <= 1'b0;
      line_count <= '0;
      locked <= 1'b0;
      mode_changed <= 1'b0;
      _480p_active_n <= 1'b1;
`ifdef FIELD_DETECT_EN
      field_r <= 1'b0;
`endif
    end else begin
      hs_r <= hsync_n;
      hs_p <= hs_r;
      vs_r <= vsync_n;
      vs_p <= vs_r;
      mode_changed <= 1'b0;
      cnt <= vs_fall ? '0 : cnt_next;
      wd <= vs_fall ? '0 : (wd == '1 ? wd : wd + 1'b1);
      if (vs_fall) begin
        line_count <= cnt_next;
`ifdef FIELD_DETECT_EN
        if (!cls) field_r <= cnt_next[0];
`endif
        case (state)
          SEARCH: state <= MEASURE;
          MEASURE: begin
            cand <= cls;
            stable <= stable_next;
            if (qualified) begin
              state <= LOCKED;
              locked <= 1'b1;
              _480p_active_n <= !cls;
              mode_changed <= _480p_active_n != !cls;
            end
          end
          default: if (cls != cand) begin
            cand <= cls;
            stable <= 4'd1;
            state <= MEASURE;
            locked <= 1'b0;
          end
        endcase
      end else if (wd == '1) begin
        // Sync loss drops lock but keeps the last mode so the PLL is not disturbed.
        state <= SEARCH;
        locked <= 1'b0;
        stable <= '0;
      end
    end
endmodule

// File: doc/video_mode_detector.md
Name: video_mode_detector

Overview:
- Measures incoming Dreamcast video sync timing and decides whether the source is 480p or 480i.
- Drives the active-low 480p flag consumed by the downstream configuration stage, which selects clock config and line doubler.
- Sits directly after the video input capture, in the Dreamcast pixel clock domain.
- Filters mode changes through a consecutive-frame stability counter so that glitches and mode switches never toggle the PLL config spuriously.

Parameters:
- LINE_CNT_W, 11, width of hsync-per-vsync line counter; saturates at all-ones.
- THRESH_480P, 400, line count at or above which a frame/field is classified 480p.
- STABLE_FRAMES, 4, consecutive identical classifications required before the output changes (range 1..15).
- TIMEOUT_W, 22, width of vsync watchdog counter; loss declared when it reaches all-ones.

Ports:
- clock  input  1  Dreamcast pixel clock.
- reset  input  1  asynchronous, active-high reset.
- hsync_n  input  1  active-low horizontal sync, synchronous to clock.
- vsync_n  input  1  active-low vertical sync, synchronous to clock.
- _480p_active_n  output  1  0 = 480p detected, 1 = 480i/unknown.
- mode_changed  output  1  one-cycle pulse when _480p_active_n changes.
- locked  output  1  1 while a stable classification is held and vsync is present.
- line_count  output  LINE_CNT_W  line count of the last completed frame/field.

Behaviour:
- Reset values (asynchronous): _480p_active_n=1, mode_changed=0, locked=0, line_count=0, all counters 0, state=SEARCH.
- hsync_n and vsync_n are registered once. Falling edge = previous registered 1, current registered 0.
- Line counter: +1 on each hsync falling edge; saturates at 2^LINE_CNT_W-1.
- On a vsync falling edge:
  - line_count latches the counter value. If an hsync edge occurs in the same cycle, that edge is included.
  - The counter restarts at 0, or at 1 if the coincident hsync edge is counted into the new frame instead. Decided: the coincident edge goes to the completed frame, and the counter restarts at 0.
  - Classification: cls = (latched count >= THRESH_480P).
- States:
  - SEARCH: waits for the first vsync edge and discards that partial frame. -> MEASURE.
  - MEASURE: on each vsync edge, compare cls with cand.
    - If equal, stable_cnt = min(stable_cnt+1, STABLE_FRAMES).
    - Otherwise cand=cls and stable_cnt=1.
    - When stable_cnt reaches STABLE_FRAMES: -> LOCKED, and _480p_active_n = !cand.
  - LOCKED: locked=1. A vsync edge whose cls differs from the held mode sets cand=cls, stable_cnt=1, and -> MEASURE. The output holds its old value until re-qualified.
- Output update timing: _480p_active_n updates in the cycle after the qualifying vsync edge (edge detect + 1). mode_changed pulses in that same cycle only if the value actually changed.
- Watchdog:
  - Counts clocks and clears on every vsync edge.
  - On reaching all-ones: state=SEARCH, locked=0, stable_cnt=0. _480p_active_n holds its last value; loss never forces a mode change. The watchdog then holds at all-ones until the next vsync edge.
- Simultaneous watchdog expiry and vsync edge: the vsync edge wins, and the watchdog clears.
- Reset mid-frame: everything returns to reset values immediately. The first post-reset frame is discarded.

Optional Feature:
- FIELD_DETECT_EN:
  - When defined, adds output field (1 bit, reset 0), updated on every vsync edge while cls=480i.
  - field=1 when the latched count is odd (263-line field), 0 when even (262).
  - field is forced 0 while _480p_active_n=0.
- Without the macro: no field port and no related logic.

Test Plan:
- Reset, then 6 frames of 525 lines -> _480p_active_n goes 1->0 one cycle after the 5th vsync edge (first frame discarded, 4 qualifying frames). mode_changed pulses once; locked=1; line_count=525.
- Locked 480p, then 6 fields of 262/263 lines -> output stays 0 through 3 fields. It goes to 1 after the 4th 480i field; mode_changed pulses once.
- Locked 480p, one 262-line glitch frame, then 525-line frames -> _480p_active_n stays 0 and mode_changed never pulses. locked drops after the glitch and returns after 4 good frames.
- Locked, then vsync held high for 2^TIMEOUT_W clocks -> locked=0, _480p_active_n unchanged; 4 matching frames after vsync resumes restore locked=1.
- hsync and vsync falling in the same cycle on a 525-line frame -> line_count=525; next frame counts from 0.
- FIELD_DETECT_EN with alternating 263/262 fields -> field toggles 1,0,1,0 one cycle after each vsync edge.
